// File: rtl/bp_me_mem_cmd_arbiter_pkg.sv
// Shared constants and helpers for the memory command arbiter.
// - Config selectors stand in for the bp_params_p configuration enum.
// - cce_mem_msg_width(): width of one memory command/response message for a config.
// - safe_clog2(): clog2 that never returns 0, used for index widths.
package bp_me_mem_cmd_arbiter_pkg;

  localparam int unsigned BpCfgFlowvar = 0;
  localparam int unsigned BpCfgNarrow  = 1;

  function automatic int unsigned cce_mem_msg_width(input int unsigned cfg);
    return (cfg == BpCfgNarrow) ? 32 : 64;
  endfunction

  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bp_me_mem_cmd_arbiter_idq.sv
// In-order ID queue: a small circular FIFO recording which requester owns each
// outstanding command.
// Ports: clk_i/reset_i (sync, active-high); push side data_i/v_i/ready_o
// (ready/valid); pop side data_o/v_o/yumi_i (yumi: consumer pops when data_o used).
module bp_me_mem_cmd_arbiter_idq
  import bp_me_mem_cmd_arbiter_pkg::*;
#(
  parameter int unsigned width_p = 1,
  parameter int unsigned els_p = 4,
  localparam int unsigned ptr_w_lp = safe_clog2(els_p),
  localparam int unsigned cnt_w_lp = $clog2(els_p + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);

  logic [width_p-1:0]  r_mem [els_p];
  logic [ptr_w_lp-1:0] r_wptr, r_rptr;
  logic [cnt_w_lp-1:0] r_cnt;
  logic                w_push, w_pop;

  function automatic logic [ptr_w_lp-1:0] next_ptr(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign ready_o = (r_cnt != cnt_w_lp'(els_p));
  assign v_o     = (r_cnt != '0);
  assign data_o  = r_mem[r_rptr];
  assign w_push  = v_i & ready_o;
  assign w_pop   = yumi_i & v_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= next_ptr(r_wptr);
      if (w_pop)  r_rptr <= next_ptr(r_rptr);
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
    end
  end

  // Storage needs no reset; validity is tracked by r_cnt.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= data_i;
  end

endmodule

// File: rtl/bp_me_mem_cmd_arbiter.sv
// Shares one memory command/response channel pair between num_req_p requesters.
// Commands: round-robin grant from rr pointer, limited by a credit counter of
// max_outstanding_p. Responses: routed to the owner recorded in an in-order ID queue.
// Ports: clk_i/reset_i (sync, active-high); mem_cmd_i/mem_cmd_v_i/mem_cmd_ready_o
// (requester side, requester 0 in LSBs); mem_cmd_o/mem_cmd_v_o/mem_cmd_ready_i
// (memory side); mem_resp_i/mem_resp_v_i/mem_resp_yumi_o (memory side);
// mem_resp_o/mem_resp_v_o/mem_resp_yumi_i (requester side); idle_o.
module bp_me_mem_cmd_arbiter
  import bp_me_mem_cmd_arbiter_pkg::*;
#(
  parameter int unsigned bp_params_p = BpCfgFlowvar,
  parameter int unsigned num_req_p = 2,
  parameter int unsigned max_outstanding_p = 4,
  localparam int unsigned cce_mem_msg_width_lp = cce_mem_msg_width(bp_params_p),
  localparam int unsigned lg_num_req_lp = safe_clog2(num_req_p)
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic [num_req_p*cce_mem_msg_width_lp-1:0] mem_cmd_i,
  input  logic [num_req_p-1:0]                      mem_cmd_v_i,
  output logic [num_req_p-1:0]                      mem_cmd_ready_o,
  output logic [cce_mem_msg_width_lp-1:0]           mem_cmd_o,
  output logic                                      mem_cmd_v_o,
  input  logic                                      mem_cmd_ready_i,
  input  logic [cce_mem_msg_width_lp-1:0]           mem_resp_i,
  input  logic                                      mem_resp_v_i,
  output logic                                      mem_resp_yumi_o,
  output logic [cce_mem_msg_width_lp-1:0]           mem_resp_o,
  output logic [num_req_p-1:0]                      mem_resp_v_o,
  input  logic [num_req_p-1:0]                      mem_resp_yumi_i,
  output logic                                      idle_o
);

  localparam int unsigned CntW = $clog2(max_outstanding_p + 1);

  logic [CntW-1:0]          r_cnt;
  logic [lg_num_req_lp-1:0] r_rr;
  logic [lg_num_req_lp-1:0] w_grant_idx, w_head;
  logic [num_req_p-1:0]     w_grant;
  int unsigned              w_idx;
  logic                     w_found, w_credit_ok, w_cmd_hs, w_head_v, w_idq_ready, w_resp_ok;

  // Registered count only: a same-cycle pop does not free a credit. Reset gates
  // everything so outputs are quiet while reset is held.
  assign w_credit_ok = ~reset_i & (r_cnt < CntW'(max_outstanding_p)) & w_idq_ready;

  // Rotating priority: scan from r_rr upward, first valid requester wins.
  always_comb begin
    w_found     = 1'b0;
    w_idx       = 0;
    w_grant_idx = '0;
    mem_cmd_o   = '0;
    for (int k = 0; k < int'(num_req_p); k++) begin
      w_idx = (int'(r_rr) + k) % num_req_p;
      if (!w_found && mem_cmd_v_i[w_idx]) begin
        w_found     = 1'b1;
        w_grant_idx = lg_num_req_lp'(w_idx);
        mem_cmd_o   = mem_cmd_i[w_idx*cce_mem_msg_width_lp +: cce_mem_msg_width_lp];
      end
    end
  end

  assign w_grant         = w_found ? ({{(num_req_p-1){1'b0}}, 1'b1} << w_grant_idx) : '0;
  assign mem_cmd_v_o     = (|mem_cmd_v_i) & w_credit_ok;
  assign mem_cmd_ready_o = w_grant & {num_req_p{mem_cmd_ready_i & w_credit_ok}};
  assign w_cmd_hs        = mem_cmd_v_o & mem_cmd_ready_i;

  bp_me_mem_cmd_arbiter_idq #(
    .width_p(lg_num_req_lp),
    .els_p  (max_outstanding_p)
  ) u_idq (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .data_i (w_grant_idx),
    .v_i    (w_cmd_hs),
    .ready_o(w_idq_ready),
    .data_o (w_head),
    .v_o    (w_head_v),
    .yumi_i (mem_resp_yumi_o)
  );

  assign w_resp_ok       = ~reset_i & mem_resp_v_i & w_head_v;
  assign mem_resp_o      = mem_resp_i;
  assign mem_resp_v_o    = w_resp_ok ? ({{(num_req_p-1){1'b0}}, 1'b1} << w_head) : '0;
  // Only the head owner's yumi counts; yumi from anyone else is ignored.
  assign mem_resp_yumi_o = w_resp_ok & mem_resp_yumi_i[w_head];
  assign idle_o          = reset_i | (r_cnt == '0);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_cnt <= '0;
      r_rr  <= '0;
    end else begin
      if (w_cmd_hs && !mem_resp_yumi_o)      r_cnt <= r_cnt + 1'b1;
      else if (!w_cmd_hs && mem_resp_yumi_o) r_cnt <= r_cnt - 1'b1;
      if (w_cmd_hs) begin
        r_rr <= (w_grant_idx == lg_num_req_lp'(num_req_p - 1)) ? '0 : w_grant_idx + 1'b1;
      end
    end
  end

  // A response with nothing outstanding means the memory side misbehaved.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(mem_resp_v_i && !w_head_v))
        else $warning("mem_resp_v_i asserted with no outstanding command");
    end
  end

endmodule

// File: tb/tb_bp_me_mem_cmd_arbiter.sv
module tb_bp_me_mem_cmd_arbiter;
  import bp_me_mem_cmd_arbiter_pkg::*;

  localparam int N    = 2;
  localparam int MAXO = 4;
  localparam int W    = cce_mem_msg_width(BpCfgFlowvar);

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] cmd_i;
  logic [N-1:0]   cmd_v_i, cmd_ready_o, resp_v_o, resp_yumi_i;
  logic [W-1:0]   cmd_o, resp_i, resp_o;
  logic           cmd_v_o, cmd_ready_i, resp_v_i, resp_yumi_o, idle_o;

  always #5 clk = ~clk;

  bp_me_mem_cmd_arbiter #(
    .bp_params_p      (BpCfgFlowvar),
    .num_req_p        (N),
    .max_outstanding_p(MAXO)
  ) dut (
    .clk_i          (clk),
    .reset_i        (rst),
    .mem_cmd_i      (cmd_i),
    .mem_cmd_v_i    (cmd_v_i),
    .mem_cmd_ready_o(cmd_ready_o),
    .mem_cmd_o      (cmd_o),
    .mem_cmd_v_o    (cmd_v_o),
    .mem_cmd_ready_i(cmd_ready_i),
    .mem_resp_i     (resp_i),
    .mem_resp_v_i   (resp_v_i),
    .mem_resp_yumi_o(resp_yumi_o),
    .mem_resp_o     (resp_o),
    .mem_resp_v_o   (resp_v_o),
    .mem_resp_yumi_i(resp_yumi_i),
    .idle_o         (idle_o)
  );

  // Model: outstanding owners as a queue (its size is the credit count), rr pointer.
  int q[$];
  int rr;
  int n_cmp = 0;
  int n_err = 0;

  int           e_grant;
  logic         e_v, e_yumi, e_idle, e_hs;
  logic [N-1:0] e_ready, e_resp_v;

  localparam logic [W-1:0] Cmd0 = 64'h5555_0000_0000_00a0;
  localparam logic [W-1:0] Cmd1 = 64'haaaa_1111_2222_00b1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_eval();
    int i;
    e_grant = -1;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        i = (rr + k) % N;
        if (e_grant < 0 && cmd_v_i[i]) e_grant = i;
      end
    end
    e_v      = (e_grant >= 0) && !rst && (q.size() < MAXO);
    e_hs     = e_v && cmd_ready_i;
    e_ready  = e_hs ? N'(1 << e_grant) : '0;
    e_resp_v = '0;
    e_yumi   = 1'b0;
    if (!rst && q.size() > 0 && resp_v_i) begin
      e_resp_v = N'(1 << q[0]);
      e_yumi   = resp_yumi_i[q[0]];
    end
    e_idle = rst || (q.size() == 0);
  endtask

  // Compare all meaningful outputs against the model; called every cycle.
  task automatic compare();
    model_eval();
    chk("cmd_v", W'(cmd_v_o), W'(e_v));
    chk("cmd_ready", W'(cmd_ready_o), W'(e_ready));
    chk("resp_v", W'(resp_v_o), W'(e_resp_v));
    chk("resp_yumi", W'(resp_yumi_o), W'(e_yumi));
    chk("idle", W'(idle_o), W'(e_idle));
    chk("resp_data", resp_o, resp_i);
    if (e_v) chk("cmd_data", cmd_o, cmd_i[e_grant*W +: W]);
  endtask

  task automatic model_advance();
    if (rst) begin
      q.delete();
      rr = 0;
    end else begin
      if (e_yumi) void'(q.pop_front());
      if (e_hs) begin
        q.push_back(e_grant);
        rr = (e_grant + 1) % N;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
  endtask

  task automatic tock();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    tick();
    tock();
  endtask

  task automatic quiet();
    cmd_v_i = '0; cmd_ready_i = 1'b1; resp_v_i = 1'b0; resp_yumi_i = '0;
    cmd_i = {Cmd1, Cmd0}; resp_i = 64'hdead_beef_0000_0001;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    quiet();
    repeat (2) cyc();
    rst = 1'b0;
  endtask

  initial begin
    rr = 0;
    quiet();
    rst = 1'b1;
    // Reset with requesters valid: everything must stay quiet.
    cmd_v_i = 2'b11; resp_v_i = 1'b1; resp_yumi_i = 2'b11;
    repeat (2) begin
      tick();
      chk("rst_cmd_v", W'(cmd_v_o), '0);
      chk("rst_ready", W'(cmd_ready_o), '0);
      chk("rst_yumi", W'(resp_yumi_o), '0);
      chk("rst_idle", W'(idle_o), W'(1));
      tock();
    end
    rst = 1'b0;
    quiet();

    // Fairness: alternating grants, each response back to its owner.
    cmd_v_i = 2'b11; resp_yumi_i = 2'b11;
    for (int k = 0; k < 6; k++) begin
      resp_v_i = (q.size() > 0);
      tick();
      chk("fair_grant", W'(cmd_ready_o), W'((k % 2 == 0) ? 1 : 2));
      if (k > 0) chk("fair_resp", W'(resp_v_o), W'((k % 2 == 1) ? 1 : 2));
      tock();
    end

    // Credit stall.
    do_reset();
    cmd_v_i = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick(); chk("credit_fill", W'(cmd_v_o), W'(1)); tock();
    end
    tick(); chk("credit_stall", W'(cmd_v_o), '0); chk("credit_busy", W'(idle_o), '0); tock();
    resp_v_i = 1'b1; resp_yumi_i = 2'b11;
    tick(); chk("credit_same", W'(cmd_v_o), '0); chk("credit_pop", W'(resp_yumi_o), W'(1)); tock();
    resp_v_i = 1'b0;
    tick(); chk("credit_back", W'(cmd_v_o), W'(1)); tock();

    // Downstream backpressure with requester 1 granted.
    do_reset();
    cmd_v_i = 2'b01;
    cyc();
    cmd_v_i = 2'b10; cmd_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) cmd_v_i = 2'b11;
      tick();
      chk("bp_cmd", cmd_o, Cmd1);
      chk("bp_ready", W'(cmd_ready_o), '0);
      tock();
    end
    cmd_ready_i = 1'b1;
    tick(); chk("bp_release", W'(cmd_ready_o), W'(2)); tock();

    // Push and pop together at two outstanding.
    do_reset();
    cmd_v_i = 2'b11;
    repeat (2) cyc();
    cmd_v_i = 2'b01; resp_v_i = 1'b1; resp_yumi_i = 2'b11;
    tick();
    chk("sim_pop", W'(resp_yumi_o), W'(1));
    chk("sim_push", W'(cmd_ready_o), W'(1));
    tock();
    cmd_v_i = '0; resp_yumi_i = 2'b00;
    tick(); chk("sim_head", W'(resp_v_o), W'(2)); tock();
    resp_yumi_i = 2'b11;
    tick(); tock();
    tick(); chk("sim_cnt_mid", W'(idle_o), '0); tock();
    resp_v_i = 1'b0;
    tick(); chk("sim_cnt_end", W'(idle_o), W'(1)); tock();

    // Protocol errors: response with nothing outstanding, stray yumi.
    do_reset();
    resp_v_i = 1'b1; resp_yumi_i = 2'b11;
    tick(); chk("empty_yumi", W'(resp_yumi_o), '0); chk("empty_v", W'(resp_v_o), '0); tock();
    resp_v_i = 1'b0; resp_yumi_i = '0; cmd_v_i = 2'b01;
    cyc();
    cmd_v_i = '0; resp_v_i = 1'b1; resp_yumi_i = 2'b10;
    tick(); chk("stray_yumi", W'(resp_yumi_o), '0); chk("stray_v", W'(resp_v_o), W'(1)); tock();
    resp_v_i = 1'b0;
    tick(); chk("stray_nopop", W'(idle_o), '0); tock();

    // Reset mid-traffic with three outstanding.
    do_reset();
    cmd_v_i = 2'b11;
    repeat (3) cyc();
    rst = 1'b1;
    tick(); chk("mid_rst_v", W'(cmd_v_o), '0); chk("mid_rst_idle", W'(idle_o), W'(1)); tock();
    rst = 1'b0;
    tick(); chk("post_rst_grant", W'(cmd_ready_o), W'(1)); chk("post_rst_idle", W'(idle_o), W'(1));
    tock();

    // Randomized traffic including stray yumis and occasional reset.
    for (int k = 0; k < 2000; k++) begin
      rst         = ($urandom_range(0, 99) == 0);
      cmd_v_i     = N'($urandom);
      cmd_i       = {$urandom, $urandom, $urandom, $urandom};
      cmd_ready_i = ($urandom_range(0, 3) != 0);
      resp_v_i    = (q.size() > 0) && ($urandom_range(0, 2) != 0);
      resp_i      = {$urandom, $urandom};
      resp_yumi_i = N'($urandom);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
